// File: rtl/light_command_sequencer_pkg.sv
// Select codes and FSM encodings shared with the exterior/interior light blocks.
package light_command_sequencer_pkg;

  localparam logic [1:0] SEL_EXT_OFF   = 2'd0;
  localparam logic [1:0] SEL_EXT_RIGHT = 2'd1;
  localparam logic [1:0] SEL_EXT_LEFT  = 2'd2;
  localparam logic [1:0] SEL_EXT_BRK   = 2'd3;

  localparam logic [1:0] SEL_INT_ON    = 2'd0;
  localparam logic [1:0] SEL_INT_DOOR  = 2'd1;
  localparam logic [1:0] SEL_INT_OFF   = 2'd2;

  // State encodings equal the select codes so outputs come straight off the state flops.
  typedef enum logic [1:0] {
    EXT_OFF   = SEL_EXT_OFF,
    EXT_RIGHT = SEL_EXT_RIGHT,
    EXT_LEFT  = SEL_EXT_LEFT,
    EXT_HAZ   = SEL_EXT_BRK
  } ext_state_e;

  typedef enum logic [1:0] {
    INT_HOLD = SEL_INT_ON,
    INT_DOOR = SEL_INT_DOOR
  } int_state_e;

endpackage

// File: rtl/light_command_sequencer_blink_timer.sv
// Indicator blink generator: starts high on restart, toggles every BLINK_HALF cycles.
module light_command_sequencer_blink_timer #(
  parameter int BLINK_HALF = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic enable,
  output logic blink,
  output logic fall_pulse
);

  localparam int PW = $clog2(BLINK_HALF) + 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(BLINK_HALF - 1);

  logic [PW-1:0] phase_q, phase_d;
  logic          blink_q, blink_d;

  // Taken from registered state only so the FSM can use it without a comb loop.
  assign fall_pulse = blink_q && (phase_q == PHASE_LAST);
  assign blink      = blink_q;

  always_comb begin
    phase_d = phase_q;
    blink_d = blink_q;
    if (!enable) begin
      phase_d = '0;
      blink_d = 1'b0;
    end else if (restart) begin
      phase_d = '0;
      blink_d = 1'b1;
    end else if (phase_q == PHASE_LAST) begin
      phase_d = '0;
      blink_d = ~blink_q;
    end else begin
      phase_d = phase_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= '0;
      blink_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      blink_q <= blink_d;
    end
  end

endmodule

// File: rtl/light_command_sequencer.sv
// Turns stalk/hazard pulses, door and key switches into light select codes and the blink clock.
module light_command_sequencer
  import light_command_sequencer_pkg::*;
#(
  parameter int BLINK_HALF   = 4,
  parameter int TURN_FLASHES = 8,
  parameter int COURTESY     = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_hazard,
  input  logic [3:0] door,
  input  logic       key,
  output logic [1:0] select_ext,
  output logic       blink,
  output logic [1:0] select_int
);

  localparam int FW = $clog2(TURN_FLASHES) + 1;
  localparam int HW = $clog2(COURTESY) + 1;

  ext_state_e    ext_q, ext_d;
  int_state_e    int_q, int_d;
  logic [FW-1:0] flash_q, flash_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [3:0]    door_prev_q, door_prev_d;

  logic fall_pulse, restart, enable, turn_active, timeout;

  assign turn_active = (ext_q == EXT_LEFT) || (ext_q == EXT_RIGHT);
  // >= keeps the cancel armed if a both-stalks cycle swallowed the exact falling edge.
  assign timeout     = turn_active && fall_pulse && (flash_q >= FW'(TURN_FLASHES - 1));

  always_comb begin
    ext_d = ext_q;
    if (btn_hazard) begin
      if (ext_q == EXT_HAZ) ext_d = EXT_OFF;
      else                  ext_d = EXT_HAZ;
    end else if (btn_left && btn_right) begin
      ext_d = ext_q;
    end else if (btn_left) begin
      if (ext_q == EXT_LEFT)     ext_d = EXT_OFF;
      else if (ext_q != EXT_HAZ) ext_d = EXT_LEFT;
    end else if (btn_right) begin
      if (ext_q == EXT_RIGHT)    ext_d = EXT_OFF;
      else if (ext_q != EXT_HAZ) ext_d = EXT_RIGHT;
    end else if (timeout) begin
      ext_d = EXT_OFF;
    end
  end

  assign enable  = (ext_d != EXT_OFF);
  assign restart = (ext_d != ext_q) && enable;

  always_comb begin
    flash_d = flash_q;
    if (ext_d != ext_q)
      flash_d = '0;
    else if (turn_active && fall_pulse && (flash_q < FW'(TURN_FLASHES)))
      flash_d = flash_q + FW'(1);
  end

  always_comb begin
    door_prev_d = door;
    int_d       = int_q;
    hold_d      = hold_q;
    case (int_q)
      INT_DOOR: begin
        if ((door_prev_q != 4'd0) && (door == 4'd0) && !key) begin
          int_d  = INT_HOLD;
          hold_d = HW'(COURTESY);
        end
      end
      INT_HOLD: begin
        if ((door != 4'd0) || key || (hold_q == HW'(1))) begin
          int_d  = INT_DOOR;
          hold_d = '0;
        end else begin
          hold_d = hold_q - HW'(1);
        end
      end
      default: begin
        int_d  = INT_DOOR;
        hold_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ext_q       <= EXT_OFF;
      flash_q     <= '0;
      int_q       <= INT_DOOR;
      hold_q      <= '0;
      door_prev_q <= 4'd0;
    end else begin
      ext_q       <= ext_d;
      flash_q     <= flash_d;
      int_q       <= int_d;
      hold_q      <= hold_d;
      door_prev_q <= door_prev_d;
    end
  end

  light_command_sequencer_blink_timer #(
    .BLINK_HALF (BLINK_HALF)
  ) u_blink (
    .clk        (clk),
    .rst        (rst),
    .restart    (restart),
    .enable     (enable),
    .blink      (blink),
    .fall_pulse (fall_pulse)
  );

  assign select_ext = ext_q;
  assign select_int = int_q;

endmodule

// File: tb/tb_light_command_sequencer.sv
// Directed bench for light_command_sequencer with hand-computed expectations.
module tb_light_command_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_left = 1'b0, btn_right = 1'b0, btn_hazard = 1'b0;
  logic [3:0] door = 4'd0;
  logic       key = 1'b0;
  logic [1:0] select_ext, select_int;
  logic       blink;

  int checks = 0;
  int errors = 0;

  light_command_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_hazard (btn_hazard),
    .door       (door),
    .key        (key),
    .select_ext (select_ext),
    .blink      (blink),
    .select_int (select_int)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic l, input logic r, input logic h);
    btn_left = l; btn_right = r; btn_hazard = h;
    tick();
    btn_left = 1'b0; btn_right = 1'b0; btn_hazard = 1'b0;
  endtask

  task automatic chk_all(input string tag, input logic [1:0] e, input logic b, input logic [1:0] i);
    chk({tag, "_ext"}, {6'd0, select_ext}, {6'd0, e});
    chk({tag, "_blink"}, {7'd0, blink}, {7'd0, b});
    chk({tag, "_int"}, {6'd0, select_int}, {6'd0, i});
  endtask

  // Blink expected i cycles after entering an indication: high 4, low 4, ...
  function automatic logic exp_blink(input int i);
    return ((i / 4) % 2) == 0;
  endfunction

  initial begin
    // 1: reset and idle
    rst = 1'b1;
    repeat (3) tick();
    chk_all("reset", 2'd0, 1'b0, 2'd1);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_all("idle", 2'd0, 1'b0, 2'd1);
    end

    // 2: left indication and self-cancel
    pulse(1'b1, 1'b0, 1'b0);
    chk_all("left_entry", 2'd2, 1'b1, 2'd1);
    for (int i = 1; i < 60; i++) begin
      tick();
      chk("left_ext", {6'd0, select_ext}, 8'd2);
      chk("left_blink", {7'd0, blink}, {7'd0, exp_blink(i)});
    end
    repeat (5) tick();
    chk_all("left_cancel", 2'd0, 1'b0, 2'd1);

    // 3: left -> right restarts blink and flash count; right again toggles off
    pulse(1'b1, 1'b0, 1'b0);
    repeat (5) tick();
    chk("left2_blink_low", {7'd0, blink}, 8'd0);
    pulse(1'b0, 1'b1, 1'b0);
    chk_all("right_entry", 2'd1, 1'b1, 2'd1);
    for (int i = 1; i < 60; i++) begin
      tick();
      chk("right_ext", {6'd0, select_ext}, 8'd1);
      chk("right_blink", {7'd0, blink}, {7'd0, exp_blink(i)});
    end
    pulse(1'b0, 1'b1, 1'b0);
    chk_all("right_off", 2'd0, 1'b0, 2'd1);

    // 4: both stalks ignored, hazard priority, hazard never cancels
    pulse(1'b1, 1'b1, 1'b0);
    chk_all("both_off", 2'd0, 1'b0, 2'd1);
    pulse(1'b1, 1'b0, 1'b0);
    tick(); tick();
    pulse(1'b1, 1'b1, 1'b0);
    chk_all("both_left", 2'd2, 1'b1, 2'd1);
    pulse(1'b1, 1'b0, 1'b1);
    chk_all("haz_entry", 2'd3, 1'b1, 2'd1);
    for (int i = 1; i <= 210; i++) begin
      tick();
      chk("haz_ext", {6'd0, select_ext}, 8'd3);
      chk("haz_blink", {7'd0, blink}, {7'd0, exp_blink(i)});
    end
    pulse(1'b1, 1'b0, 1'b0);
    chk("haz_ignore_left", {6'd0, select_ext}, 8'd3);
    pulse(1'b0, 1'b0, 1'b1);
    chk_all("haz_off", 2'd0, 1'b0, 2'd1);

    // 5: courtesy hold, full length then early reopen, then key blocks hold
    door = 4'b0010; tick();
    door = 4'b0000; tick();
    chk("hold_entry", {6'd0, select_int}, 8'd0);
    for (int i = 1; i < 32; i++) begin
      tick();
      chk("hold_run", {6'd0, select_int}, 8'd0);
    end
    tick();
    chk("hold_expire", {6'd0, select_int}, 8'd1);
    door = 4'b0010; tick();
    door = 4'b0000; tick();
    chk("hold2_entry", {6'd0, select_int}, 8'd0);
    for (int i = 1; i < 10; i++) begin
      tick();
      chk("hold2_run", {6'd0, select_int}, 8'd0);
    end
    door = 4'b0010; tick();
    chk("hold2_reopen", {6'd0, select_int}, 8'd1);
    door = 4'b0000; key = 1'b1; tick();
    chk("key_blocks_hold", {6'd0, select_int}, 8'd1);
    tick();
    chk("key_blocks_hold2", {6'd0, select_int}, 8'd1);
    key = 1'b0;

    // 6: reset during hazard and hold
    door = 4'b1000; tick();
    door = 4'b0000;
    pulse(1'b0, 1'b0, 1'b1);
    chk_all("pre_rst", 2'd3, 1'b1, 2'd0);
    tick(); tick();
    rst = 1'b1; tick();
    chk_all("mid_rst", 2'd0, 1'b0, 2'd1);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_all("post_rst", 2'd0, 1'b0, 2'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
